// File: rtl/mac_pkg.sv
// Shared types and constants for the MAC accumulator datapath.
package mac_pkg;

   localparam int unsigned OP_W   = 4;
   localparam int unsigned PROD_W = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } mac_state_t;

endpackage

// File: rtl/wallace_tree_multiplier.sv
// 4x4 multiplier, signed A by unsigned B, 8-bit product. Partial products are
// reduced with two carry-save layers and one final carry-propagate add.
module wallace_tree_multiplier
   import mac_pkg::*;
(
   input  logic [OP_W-1:0]   a,
   input  logic [OP_W-1:0]   b,
   output logic [PROD_W-1:0] z
);

   logic [PROD_W-1:0] a_ext;
   logic [PROD_W-1:0] pp [OP_W];
   logic [PROD_W-1:0] s1, c1, s2, c2;

   always_comb begin
      a_ext = {{(PROD_W-OP_W){a[OP_W-1]}}, a};
      for (int unsigned i = 0; i < OP_W; i++) begin
         pp[i] = b[i] ? (a_ext << i) : '0;
      end
      // Mod-2^8 arithmetic keeps the sign-extended rows exact for the product range.
      s1 = pp[0] ^ pp[1] ^ pp[2];
      c1 = ((pp[0] & pp[1]) | (pp[0] & pp[2]) | (pp[1] & pp[2])) << 1;
      s2 = s1 ^ c1 ^ pp[3];
      c2 = ((s1 & c1) | (s1 & pp[3]) | (c1 & pp[3])) << 1;
      z  = s2 + c2;
   end

endmodule

// File: rtl/mac_accumulator.sv
// Burst multiply-accumulate stage with a registered product and valid/ready ports.
// Define MAC_SAT_EN to saturate each addition and report clamping on ovf.
module mac_accumulator
   import mac_pkg::*;
#(
   parameter int unsigned ACC_W = 12,
   parameter int unsigned LEN_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [LEN_W-1:0] len,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [OP_W-1:0]  a,
   input  logic [OP_W-1:0]  b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] acc_out,
   output logic             busy,
   output logic             ovf
);

   mac_state_t        state_q, state_d;
   logic [LEN_W-1:0]  rem_q, rem_d;
   logic [ACC_W-1:0]  acc_q, acc_d;
   logic [PROD_W-1:0] p_q, p_d;
   logic              p_v_q, p_v_d;
   logic [PROD_W-1:0] prod;
   logic [ACC_W-1:0]  p_ext;
   logic              hs;

`ifdef MAC_SAT_EN
   localparam logic [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic [ACC_W-1:0] SAT_MIN = ~SAT_MAX;
   logic              ovf_q, ovf_d;
   logic [ACC_W:0]    sum_w;
`endif

   wallace_tree_multiplier u_mul (
      .a (a),
      .b (b),
      .z (prod)
   );

   assign in_ready  = (state_q == RUN);
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign acc_out   = acc_q;
   assign hs        = in_valid && in_ready;
`ifdef MAC_SAT_EN
   assign ovf       = ovf_q;
`else
   assign ovf       = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      acc_d   = acc_q;
      p_d     = p_q;
      p_v_d   = 1'b0;
      p_ext   = ACC_W'($signed(p_q));
`ifdef MAC_SAT_EN
      ovf_d   = ovf_q;
      sum_w   = {acc_q[ACC_W-1], acc_q} + {p_ext[ACC_W-1], p_ext};
`endif

      if (p_v_q) begin
`ifdef MAC_SAT_EN
         if (sum_w[ACC_W] != sum_w[ACC_W-1]) begin
            acc_d = sum_w[ACC_W] ? SAT_MIN : SAT_MAX;
            ovf_d = 1'b1;
         end else begin
            acc_d = sum_w[ACC_W-1:0];
         end
`else
         acc_d = acc_q + p_ext;
`endif
      end

      unique case (state_q)
         IDLE: begin
            if (start) begin
               acc_d = '0;
`ifdef MAC_SAT_EN
               ovf_d = 1'b0;
`endif
               if (len != '0) begin
                  rem_d   = len;
                  state_d = RUN;
               end else begin
                  state_d = DONE;
               end
            end
         end
         RUN: begin
            if (hs) begin
               p_d   = prod;
               p_v_d = 1'b1;
               rem_d = rem_q - LEN_W'(1);
               if (rem_q == LEN_W'(1)) state_d = DRAIN;
            end
         end
         DRAIN: state_d = DONE;
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         rem_q   <= '0;
         acc_q   <= '0;
         p_q     <= '0;
         p_v_q   <= 1'b0;
`ifdef MAC_SAT_EN
         ovf_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         acc_q   <= acc_d;
         p_q     <= p_d;
         p_v_q   <= p_v_d;
`ifdef MAC_SAT_EN
         ovf_q   <= ovf_d;
`endif
      end
   end

endmodule
